// File: rtl/present80_inv_key_schedule.sv
// PRESENT-80 decryption-side key schedule.
// Expands the master key forward to the K32 state, then walks it back one
// inverse update per accepted round key, delivering K32 down to K1.
// Optional macro PRESENT_INV_KS_CACHE_EN: remembers the last expanded key and
// its K32 state so that a repeated start can skip the expansion.
module present80_inv_key_schedule (
    input  logic        clk,
    input  logic        rstn,
    input  logic [79:0] key,
    input  logic        start,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [63:0] round_key,
    output logic [5:0]  round_idx,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DELIVER} state_t;

    state_t      r_state, w_state_nxt;
    logic [79:0] r_key,   w_key_nxt;
    logic [4:0]  r_cnt,   w_cnt_nxt;
    logic [5:0]  r_idx,   w_idx_nxt;
    logic        r_done,  w_done_nxt;

    logic        w_hs;
    logic        w_hit;
    logic [79:0] w_hit_key;
    logic [79:0] w_rot, w_fwd, w_x, w_inv;
    logic [4:0]  w_c;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    // Forward update: rotate left 61, S-box top nibble, mix in round counter.
    assign w_rot = {r_key[18:0], r_key[79:19]};
    assign w_fwd = {sbox(w_rot[79:76]), w_rot[75:20], w_rot[19:15] ^ r_cnt, w_rot[14:0]};

    // Inverse update: undo the counter, inverse S-box, rotate right 61.
    assign w_c   = r_idx[4:0] - 5'd1;
    assign w_x   = {sbox_inv(r_key[79:76]), r_key[75:20], r_key[19:15] ^ w_c, r_key[14:0]};
    assign w_inv = {w_x[60:0], w_x[79:61]};

    assign w_hs  = (r_state == S_DELIVER) && rk_ready;

`ifdef PRESENT_INV_KS_CACHE_EN
    logic [79:0] r_cached_key;
    logic [79:0] r_cached_k32;
    logic        r_cache_vld;

    assign w_hit     = r_cache_vld && (key == r_cached_key);
    assign w_hit_key = r_cached_k32;

    // Cache bookkeeping. The key is captured at start and the entry is
    // invalidated there; it becomes valid again once K32 is reached. The
    // block is busy in between, so this matches committing both at K32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cached_key <= '0;
            r_cached_k32 <= '0;
            r_cache_vld  <= 1'b0;
        end else if ((r_state == S_IDLE) && start && !w_hit) begin
            r_cached_key <= key;
            r_cache_vld  <= 1'b0;
        end else if ((r_state == S_EXPAND) && (r_cnt == 5'd31)) begin
            r_cached_k32 <= w_fwd;
            r_cache_vld  <= 1'b1;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_key = '0;
`endif

    // Next-state and datapath update selection.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_hit) begin
                        w_key_nxt   = w_hit_key;
                        w_idx_nxt   = 6'd32;
                        w_state_nxt = S_DELIVER;
                    end else begin
                        w_key_nxt   = key;
                        w_cnt_nxt   = 5'd1;
                        w_state_nxt = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                w_key_nxt = w_fwd;
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_idx_nxt   = 6'd32;
                    w_state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (w_hs) begin
                    if (r_idx == 6'd1) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_key_nxt = w_inv;
                        w_idx_nxt = r_idx - 6'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Key, counter, index and done-pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_key  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_key  <= w_key_nxt;
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign rk_valid  = (r_state == S_DELIVER);
    assign round_key = r_key[79:16];
    assign round_idx = r_idx;
    assign done      = r_done;

endmodule

// File: tb/tb_present80_inv_key_schedule.sv
// Self-checking bench for present80_inv_key_schedule. Reference round keys
// come from the forward PRESENT-80 schedule written with 80-bit arithmetic.
module tb_present80_inv_key_schedule;

`ifdef PRESENT_INV_KS_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        rk_ready = 1'b0;
    logic [79:0] key = '0;
    logic        busy, rk_valid, done;
    logic [63:0] round_key;
    logic [5:0]  round_idx;

    int checks = 0;
    int errors = 0;

    logic [3:0]  SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [63:0] ref_rk [1:32];
    bit          m_vld = 1'b0;
    logic [79:0] m_ckey = '0;

    logic [63:0] obs_key [32];
    logic [5:0]  obs_idx [32];
    logic [63:0] tr_key [$];
    logic [5:0]  tr_idx [$];
    bit          tr_vld [$];
    bit          tr_rdy [$];
    int          done_early;
    logic        done_final, valid_final, busy_final;

    always #5 clk = ~clk;

    present80_inv_key_schedule dut (
        .clk       (clk),
        .rstn      (rstn),
        .key       (key),
        .start     (start),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    // Forward key schedule: ref_rk[i] = K_i.
    function automatic void ref_sched(input logic [79:0] mk);
        logic [79:0] k;
        k = mk;
        for (int i = 1; i <= 32; i++) begin
            ref_rk[i] = k[79:16];
            if (i < 32) begin
                k = (k << 61) | (k >> 19);
                k[79:76] = SBOX[k[79:76]];
                k = k ^ (80'(i) << 15);
            end
        end
    endfunction

    function automatic int exp_lat(input logic [79:0] k);
        return (CACHE && m_vld && (m_ckey == k)) ? 1 : 32;
    endfunction

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Starts at the current negedge, collects 32 accepted keys, returns in the done cycle.
    task automatic run_seq(input logic [79:0] k, input int ready_pct, input int pulse_at,
                           input logic [79:0] k2, output int lat, output bit tmo);
        int n;
        int cyc;
        tmo = 1'b0; n = 0; cyc = 0; done_early = 0;
        tr_key.delete(); tr_idx.delete(); tr_vld.delete(); tr_rdy.delete();
        key = k; start = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!rk_valid && lat < 64) begin
            if (done) done_early++;
            if (lat == pulse_at) begin key = k2; start = 1'b1; end
            @(negedge clk);
            start = 1'b0; lat++;
        end
        if (!rk_valid) begin tmo = 1'b1; return; end
        m_vld = 1'b1; m_ckey = k;
        while (n < 32 && cyc < 2000) begin
            rk_ready = ($urandom_range(99) < ready_pct);
            tr_vld.push_back(rk_valid); tr_rdy.push_back(rk_ready);
            tr_key.push_back(round_key); tr_idx.push_back(round_idx);
            if (done) done_early++;
            if (rk_valid && rk_ready) begin
                obs_key[n] = round_key; obs_idx[n] = round_idx; n++;
            end
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        if (n < 32) tmo = 1'b1;
        done_final = done; valid_final = rk_valid; busy_final = busy;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, rk_valid, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got busy/valid/done %b want 000", {busy, rk_valid, done});
        end
        checks++;
        if (round_key !== 64'h0) begin
            errors++; $display("FAIL reset_round_key: got %h want 0", round_key);
        end
        checks++;
        if (round_idx !== 6'd0) begin
            errors++; $display("FAIL reset_round_idx: got %0d want 0", round_idx);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_key();
        int lat, e, bad;
        bit tmo;
        ref_sched(80'h0);
        e = exp_lat(80'h0);
        run_seq(80'h0, 100, 0, 80'h0, lat, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL zero_timeout: sequence did not complete"); end
        checks++;
        if (lat != e) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, e); end
        checks++;
        if (obs_idx[0] !== 6'd32) begin errors++; $display("FAIL zero_first_idx: got %0d want 32", obs_idx[0]); end
        checks++;
        if (obs_key[30] !== 64'hC000_0000_0000_0000 || obs_idx[30] !== 6'd2) begin
            errors++; $display("FAIL zero_k2: got idx %0d key %h want idx 2 key c000000000000000", obs_idx[30], obs_key[30]);
        end
        checks++;
        if (obs_key[31] !== 64'h0 || obs_idx[31] !== 6'd1) begin
            errors++; $display("FAIL zero_k1: got idx %0d key %h want idx 1 key 0", obs_idx[31], obs_key[31]);
        end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL zero_seq: got %0d wrong entries want 0", bad); end
        checks++;
        if (tr_vld.size() != 32) begin errors++; $display("FAIL zero_throughput: got %0d cycles want 32", tr_vld.size()); end
        checks++;
        if (done_early != 0 || done_final !== 1'b1) begin
            errors++; $display("FAIL zero_done: got early %0d final %b want 0 and 1", done_early, done_final);
        end
        checks++;
        if (valid_final !== 1'b0 || busy_final !== 1'b0) begin
            errors++; $display("FAIL zero_done_cycle: got valid %b busy %b want 0 0", valid_final, busy_final);
        end
    endtask

    task automatic test_ones_key();
        int lat, e, bad;
        bit tmo;
        logic [79:0] k;
        k = '1;
        ref_sched(k);
        e = exp_lat(k);
        run_seq(k, 100, 0, 80'h0, lat, tmo);
        checks++;
        if (tmo || lat != e) begin errors++; $display("FAIL ones_latency: got %0d tmo %0d want %0d", lat, tmo, e); end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ones_seq: got %0d wrong entries want 0", bad); end
        checks++;
        if (obs_key[31] !== 64'hFFFF_FFFF_FFFF_FFFF || obs_idx[31] !== 6'd1) begin
            errors++; $display("FAIL ones_last: got idx %0d key %h want idx 1 key ffffffffffffffff", obs_idx[31], obs_key[31]);
        end
    endtask

    task automatic test_backpressure();
        int lat, e, bad, hold_bad, stalls;
        bit tmo;
        logic [79:0] k;
        for (int t = 0; t < 3; t++) begin
            k = rand80();
            ref_sched(k);
            e = exp_lat(k);
            run_seq(k, 50, 0, 80'h0, lat, tmo);
            checks++;
            if (tmo || lat != e) begin errors++; $display("FAIL bp_latency[%0d]: got %0d tmo %0d want %0d", t, lat, tmo, e); end
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL bp_seq[%0d]: got %0d wrong entries want 0", t, bad); end
            hold_bad = 0; stalls = 0;
            for (int i = 0; i + 1 < tr_vld.size(); i++)
                if (tr_vld[i] && !tr_rdy[i]) begin
                    stalls++;
                    if (!tr_vld[i+1] || tr_key[i+1] !== tr_key[i] || tr_idx[i+1] !== tr_idx[i]) hold_bad++;
                end
            checks++;
            if (hold_bad != 0) begin
                errors++; $display("FAIL bp_hold[%0d]: got %0d unstable stalls of %0d want 0", t, hold_bad, stalls);
            end
        end
    endtask

    task automatic test_start_ignored_and_done_start();
        int lat, e, bad;
        bit tmo;
        logic [79:0] k, k2, k3;
        k = rand80(); k2 = ~k; k3 = rand80();
        ref_sched(k);
        e = exp_lat(k);
        run_seq(k, 100, 10, k2, lat, tmo);
        checks++;
        if (tmo || lat != e) begin errors++; $display("FAIL busy_start_latency: got %0d tmo %0d want %0d", lat, tmo, e); end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_start_seq: got %0d wrong entries want 0", bad); end
        // Still in the done cycle: this start must be accepted.
        ref_sched(k3);
        e = exp_lat(k3);
        run_seq(k3, 100, 0, 80'h0, lat, tmo);
        checks++;
        if (tmo || lat != e) begin errors++; $display("FAIL done_start_latency: got %0d tmo %0d want %0d", lat, tmo, e); end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL done_start_seq: got %0d wrong entries want 0", bad); end
    endtask

    task automatic test_reset_mid_deliver();
        int lat, e, bad, cyc, dcnt;
        bit tmo;
        logic [79:0] k;
        k = rand80();
        key = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rk_ready = 1'b1; cyc = 0;
        while (!(rk_valid && round_idx == 6'd17) && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (!(rk_valid && round_idx == 6'd17)) begin errors++; $display("FAIL rst_reach17: got idx %0d valid %b want 17 1", round_idx, rk_valid); end
        rstn = 1'b0; rk_ready = 1'b0; m_vld = 1'b0;
        #1;
        checks++;
        if ({busy, rk_valid, done} !== 3'b000 || round_key !== 64'h0 || round_idx !== 6'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got busy %b valid %b done %b key %h idx %0d want all 0",
                               busy, rk_valid, done, round_key, round_idx);
        end
        dcnt = 0;
        repeat (3) begin @(negedge clk); if (done) dcnt++; end
        rstn = 1'b1;
        repeat (2) begin @(negedge clk); if (done) dcnt++; end
        checks++;
        if (dcnt != 0) begin errors++; $display("FAIL rst_no_done: got %0d done cycles want 0", dcnt); end
        ref_sched(k);
        e = exp_lat(k);
        run_seq(k, 100, 0, 80'h0, lat, tmo);
        checks++;
        if (tmo || lat != e) begin errors++; $display("FAIL rst_restart_latency: got %0d tmo %0d want %0d", lat, tmo, e); end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_restart_seq: got %0d wrong entries want 0", bad); end
    endtask

    task automatic test_repeat_key();
        int lat, e, bad;
        bit tmo;
        logic [79:0] k, kd;
        k = rand80(); kd = k ^ 80'h1;
        ref_sched(k);
        for (int r = 0; r < 3; r++) begin
            if (r == 2) ref_sched(kd);
            e = exp_lat((r == 2) ? kd : k);
            run_seq((r == 2) ? kd : k, 70, 0, 80'h0, lat, tmo);
            checks++;
            if (tmo || lat != e) begin errors++; $display("FAIL repeat_latency[%0d]: got %0d tmo %0d want %0d", r, lat, tmo, e); end
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (obs_key[i] !== ref_rk[32-i] || obs_idx[i] !== 6'(32 - i)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL repeat_seq[%0d]: got %0d wrong entries want 0", r, bad); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_ones_key();
        test_backpressure();
        test_start_ignored_and_done_start();
        test_reset_mid_deliver();
        test_repeat_key();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/present80_inv_key_schedule.md
# present80_inv_key_schedule

Decryption-side PRESENT-80 key schedule. It takes the 80-bit master key and delivers the 64-bit round keys in reverse order, K32 first and K1 last. Internally it runs the forward update 31 times to reach the final key state, then applies the inverse update once per consumed round key. It sits beside the encryption-side key schedule and feeds the PRESENT-80 decryption datapath over a valid/ready handshake.

## Interface
Parameters: none (80-bit key, 64-bit round key and 32 round keys are fixed by PRESENT-80).

- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous reset, active-low
- key  input  80  master key; sampled only on an accepted start
- start  input  1  request; accepted only in IDLE, ignored otherwise
- busy  output  1  high in EXPAND and DELIVER
- rk_valid  output  1  round_key/round_idx valid (DELIVER only)
- rk_ready  input  1  consumer accepts the current round key when rk_valid && rk_ready
- round_key  output  64  current round key = key_reg[79:16]
- round_idx  output  6  index of round_key, 32 down to 1
- done  output  1  one-cycle pulse after K1 is accepted

## Operation
- State machine: IDLE, EXPAND, DELIVER.
- IDLE + start:
  - key_reg <= key, cnt <= 1, go to EXPAND.
  - With PRESENT_INV_KS_CACHE_EN and a cache hit, go straight to DELIVER instead (see Configuration).
- EXPAND: each cycle applies the forward update with counter cnt, then cnt <= cnt+1. The forward update is:
  - s = {key_reg[18:0], key_reg[79:19]}
  - s[79:76] = S(s[79:76])
  - s[19:15] ^= cnt[4:0]
  - After the update that uses cnt==31, go to DELIVER with round_idx <= 32.
- DELIVER:
  - rk_valid=1. round_key and round_idx stay stable until the handshake completes.
  - On handshake with round_idx>1: apply the inverse update with c = round_idx-1, then round_idx <= round_idx-1. The inverse update is:
    - x = key_reg
    - x[19:15] ^= c[4:0]
    - x[79:76] = S⁻¹(x[79:76])
    - key_reg <= {x[60:0], x[79:61]}
  - On handshake with round_idx==1: go to IDLE and pulse done for one cycle.
- S and S⁻¹: the PRESENT 4-bit S-box (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2) and its inverse. S-box logic is local to this block.
- The 5-bit counter never reaches 0 or 32, so the XOR values stay in 1..31.

## Timing
- Reset values:
  - state=IDLE, key_reg=0, cnt=0, round_idx=0
  - busy=0, rk_valid=0, done=0, round_key=0
- Reset asserted mid-EXPAND or mid-DELIVER aborts immediately. No done pulse is produced and the in-flight key is lost.
- Latency, cache miss: start accepted on edge T0; 31 updates on edges T1..T31. rk_valid is high in the cycle after T31, i.e. 32 cycles after the start edge, with round_idx=32.
- Throughput in DELIVER: one round key per cycle while rk_ready is held high. All 32 keys take 32 cycles.
- done is high in the cycle after the K1 handshake, coincident with rk_valid=0 and busy=0. start may be accepted in that same cycle.
- start while busy: ignored, and key is not sampled.
- rk_ready asserted outside DELIVER: no effect.

## Configuration
- Macro: PRESENT_INV_KS_CACHE_EN.
- Defined:
  - Adds cached_key[79:0], cached_k32[79:0] and cache_vld.
  - On the EXPAND→DELIVER transition: cached_key <= the key sampled at start, cached_k32 <= the K32 state, cache_vld <= 1.
  - Start in IDLE with cache_vld && key==cached_key: key_reg <= cached_k32, round_idx <= 32, go straight to DELIVER. rk_valid is high 1 cycle after the start edge.
  - rstn clears cache_vld.
- Undefined: every start goes through EXPAND (32-cycle latency). The cache registers and comparator do not exist.

## Test plan
- key=0, start, rk_ready=1:
  - first rk_valid 32 cycles after start, with round_idx=32
  - round_idx=2 gives round_key=64'hC000_0000_0000_0000
  - round_idx=1 gives round_key=0
  - done pulses once
- key=80'hFFFF_FFFF_FFFF_FFFF_FFFF: the full sequence equals the forward key schedule's K1..K32 reversed (bench reference model). Last key is 64'hFFFF_FFFF_FFFF_FFFF with round_idx=1.
- Backpressure: toggle rk_ready pseudo-randomly. round_key and round_idx must hold while rk_valid && !rk_ready, with no skipped or duplicated index.
- Start pulsed during EXPAND with a different key: ignored, output sequence unchanged. Start in the done cycle: accepted, new expansion begins.
- rstn low while round_idx=17: all outputs go to their reset values immediately and no done pulse occurs. A fresh start then gives the full correct sequence.
- With PRESENT_INV_KS_CACHE_EN:
  - Repeat start with the same key: first rk_valid 1 cycle after start, identical sequence.
  - Different key: 32-cycle latency.
  - Start after a reset with the same key: 32-cycle latency.
